// File: rtl/pipeline_register.sv
// Multi-stage valid/ready pipeline register with bubble collapsing and synchronous flush.
// Stage STAGES-1 drives the outputs; any empty stage downstream lets upstream stages advance.
module pipeline_register #(
    parameter int            N          = 32,
    parameter int            STAGES     = 2,
    parameter logic [N-1:0]  RESET_DATA = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N-1:0]                    in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N-1:0]                    out_data,
    output logic [$clog2(STAGES+1)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic              vld_p  [STAGES];
    logic [N-1:0]      data_p [STAGES];
    logic [STAGES-1:0] vld_vec;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_vld;
    logic [N-1:0]      src_data [STAGES];
    logic              in_fire;

    assign in_ready = rdy[0] & ~flush;
    assign in_fire  = in_valid & in_ready;

    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_stage
        assign vld_vec[g] = vld_p[g];

        // Unrolled ready chain: a stage may advance if the consumer takes the
        // last word or any stage from here to the output is a bubble.
        assign rdy[g] = out_ready | ~(&vld_vec[STAGES-1:g]);

        if (g == 0) begin : g_head
            assign src_vld[g]  = in_fire;
            assign src_data[g] = in_data;
        end else begin : g_body
            assign src_vld[g]  = vld_p[g-1];
            assign src_data[g] = data_p[g-1];
        end

        // Stage boundary g
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_p[g]  <= 1'b0;
                data_p[g] <= RESET_DATA;
            end else if (flush) begin
                vld_p[g]  <= 1'b0;
                data_p[g] <= RESET_DATA;
            end else if (rdy[g]) begin
                vld_p[g] <= src_vld[g];
                if (src_vld[g]) begin
                    data_p[g] <= src_data[g];
                end
            end
        end
    end

    assign out_valid = vld_p[STAGES-1] & ~flush;
    assign out_data  = data_p[STAGES-1];
    assign occupancy = OCC_W'($countones(vld_vec));

endmodule

// File: tb/tb_pipeline_register.sv
// Directed bench for pipeline_register: a 3-stage 32-bit instance and a 1-stage 8-bit instance.
module tb_pipeline_register;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_out_ready;
    logic [7:0]  b_in_data;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [0:0]  b_occ;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_register #(.N(32), .STAGES(3), .RESET_DATA(32'h0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipeline_register #(.N(8), .STAGES(1), .RESET_DATA(8'h0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle mid-cycle, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0]  sbq [$];
        logic [31:0] pat;
        logic        exp_v [7];
        logic [7:0]  exp_in;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        #3;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_occ",       32'(a_occ),       32'd0);
        chk("rst_out_data",  a_out_data,       32'h0);
        chk("rst_b_valid",   32'(b_out_valid), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Mid-run reset with two words in flight
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        chk("fill_occ1", 32'(a_occ), 32'd1);
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        chk("fill_occ2", 32'(a_occ), 32'd2);
        tick();
        chk("fill_out_valid", 32'(a_out_valid), 32'd1);
        chk("fill_out_data",  a_out_data,       32'h11);
        chk("fill_occ2b",     32'(a_occ),       32'd2);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_occ",       32'(a_occ),       32'd0);
        chk("midrst_out_data",  a_out_data,       32'h0);
        tick();
        reset = 1'b0;

        // Streaming: words 1..4 on consecutive cycles, first out after 3 edges
        out_ready = 1'b1;
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) begin
            in_valid = (k < 4);
            in_data  = 32'(k + 1);
            tick();
            chk("stream_valid", 32'(a_out_valid), 32'(exp_v[k]));
            if (exp_v[k]) chk("stream_data", a_out_data, 32'(k - 1));
        end
        chk("stream_drained", 32'(a_occ), 32'd0);

        // Backpressure: 0xA,0xB,0xC fill the pipe, 0xD waits
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA; #1 chk("bp_rdyA", 32'(a_in_ready), 32'd1); tick();
        in_data = 32'hB; #1 chk("bp_rdyB", 32'(a_in_ready), 32'd1); tick();
        in_data = 32'hC; #1 chk("bp_rdyC", 32'(a_in_ready), 32'd1); tick();
        in_data = 32'hD; #1 chk("bp_rdyD", 32'(a_in_ready), 32'd0);
        chk("bp_occ", 32'(a_occ), 32'd3);
        tick();
        tick();
        chk("bp_hold_rdy",  32'(a_in_ready), 32'd0);
        chk("bp_hold_data", a_out_data,      32'hA);
        chk("bp_hold_occ",  32'(a_occ),      32'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(a_in_ready), 32'd1);
        chk("bp_out_A",       a_out_data,      32'hA);
        tick();
        in_valid = 1'b0;
        chk("bp_out_B", a_out_data, 32'hB);
        chk("bp_occ_B", 32'(a_occ), 32'd3);
        tick();
        chk("bp_out_C", a_out_data, 32'hC);
        tick();
        chk("bp_out_D", a_out_data, 32'hD);
        chk("bp_vld_D", 32'(a_out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(a_occ), 32'd0);

        // Full pipe with simultaneous input and output transfers
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = 32'h100 + 32'(j);
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 32'h103 + 32'(j);
            #1;
            chk("full_in_ready", 32'(a_in_ready), 32'd1);
            chk("full_occ",      32'(a_occ),      32'd3);
            chk("full_data",     a_out_data,      32'h100 + 32'(j));
            tick();
        end
        in_valid = 1'b0;
        #1 chk("full_tail", a_out_data, 32'h104);
        tick(); tick(); tick();
        chk("full_drained", 32'(a_occ), 32'd0);

        // Flush with 0x55/0x66 in flight and a competing input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h55; tick();
        in_data = 32'h66; tick();
        in_valid = 1'b0;
        tick();
        chk("fl_pre_occ",  32'(a_occ),  32'd2);
        chk("fl_pre_data", a_out_data,  32'h55);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        #1;
        chk("fl_in_ready",  32'(a_in_ready),  32'd0);
        chk("fl_out_valid", 32'(a_out_valid), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ",       32'(a_occ),       32'd0);
        chk("fl_post_vld",  32'(a_out_valid), 32'd0);
        chk("fl_post_data", a_out_data,       32'h0);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("fl_never", 32'(a_out_valid), 32'd0);
        end

        // Single-stage instance: alternating input, patterned output ready
        pat = 32'hB53C_96E1;
        for (int i = 0; i < 44; i++) begin
            exp_in      = 8'(i * 7 + 3);
            b_in_valid  = (i < 40) && (i % 2 == 0);
            b_in_data   = exp_in;
            b_out_ready = (i < 40) ? pat[0] : 1'b1;
            pat = {pat[30:0], pat[31]};
            #1;
            chk("b_occ_max", 32'(b_occ <= 1'b1 && b_occ == b_out_valid), 32'd1);
            if (b_out_valid && b_out_ready) begin
                chk("b_sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    chk("b_order", 32'(b_out_data), 32'(sbq[0]));
                    void'(sbq.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) sbq.push_back(b_in_data);
            tick();
        end
        chk("b_drained_q",   32'(sbq.size()),  32'd0);
        chk("b_drained_vld", 32'(b_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
